// File: rtl/vga_pkg.sv
// VGA timing constants, coordinate type and arbiter FSM states
// shared by the timing generator, frame arbiter and renderer.
package vga_pkg;

  localparam int HPIXELS = 800;
  localparam int VLINES  = 521;
  localparam int HBP     = 144;
  localparam int HFP     = 784;
  localparam int VBP     = 31;
  localparam int VFP     = 511;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    DISPLAY,
    ARB,
    SETTLE,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first pending bit at or
// above the pointer, wrapping at N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_pend,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_any && i_pend[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/frame_update_arbiter.sv
// Grants object-position writes to game-logic requesters only
// inside vertical blanking; also produces the frame tick/count.
module frame_update_arbiter #(
  parameter int N_REQ = 4,
  parameter int CW    = 10,
  parameter int VBP   = 31,
  parameter int VFP   = 511,
  parameter int FCW   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW-1:0]       vc,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] req_x,
  input  logic [N_REQ*CW-1:0] req_y,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ*CW-1:0] obj_x,
  output logic [N_REQ*CW-1:0] obj_y,
  output logic                upd_win,
  output logic                frame_tick,
  output logic [FCW-1:0]      frame_cnt
);

  import vga_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_upd_win;
  logic                r_tick;
  logic [FCW-1:0]      r_cnt;
  logic [N_REQ-1:0]    r_served;
  logic [IW-1:0]       r_ptr;
  logic [N_REQ*CW-1:0] r_obj_x;
  logic [N_REQ*CW-1:0] r_obj_y;

  logic                w_win;
  logic                w_rise;
  logic [N_REQ-1:0]    w_pend;
  logic [N_REQ-1:0]    w_rr_gnt;
  logic [IW-1:0]       w_rr_idx;
  logic                w_rr_any;
  logic [N_REQ-1:0]    w_gnt;
  logic                w_clr;

  assign w_win  = (vc >= CW'(VFP)) || (vc < CW'(VBP));
  assign w_rise = w_win & ~r_upd_win;
  assign w_pend = req & ~r_served;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .i_pend (w_pend),
    .i_ptr  (r_ptr),
    .o_gnt  (w_rr_gnt),
    .o_idx  (w_rr_idx),
    .o_any  (w_rr_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_clr       = 1'b0;
    unique case (r_state)
      DISPLAY: begin
        if (r_tick) begin
          w_clr       = 1'b1;
          w_state_nxt = ARB;
        end
      end
      ARB: begin
        // a closing window beats a pending request
        if (!r_upd_win) begin
          w_state_nxt = DISPLAY;
        end else if (&r_served) begin
          w_state_nxt = DONE;
        end else if (w_rr_any) begin
          w_gnt       = w_rr_gnt;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        w_state_nxt = r_upd_win ? ARB : DISPLAY;
      end
      DONE: begin
        if (!r_upd_win) w_state_nxt = DISPLAY;
      end
      default: w_state_nxt = DISPLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DISPLAY;
      r_upd_win <= 1'b0;
      r_tick    <= 1'b0;
      r_cnt     <= '0;
      r_served  <= '0;
      r_ptr     <= '0;
      r_obj_x   <= '0;
      r_obj_y   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_upd_win <= w_win;
      r_tick    <= w_rise;
      if (w_rise) r_cnt <= r_cnt + 1'b1;
      if (w_clr) r_served <= '0;
      else       r_served <= r_served | w_gnt;
      if (|w_gnt) begin
        r_ptr <= IW'((int'(w_rr_idx) + 1) % N_REQ);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (w_gnt[i]) begin
          r_obj_x[i*CW +: CW] <= req_x[i*CW +: CW];
          r_obj_y[i*CW +: CW] <= req_y[i*CW +: CW];
        end
      end
    end
  end

  assign gnt        = w_gnt;
  assign obj_x      = r_obj_x;
  assign obj_y      = r_obj_y;
  assign upd_win    = r_upd_win;
  assign frame_tick = r_tick;
  assign frame_cnt  = r_cnt;

endmodule

// File: tb/tb_frame_update_arbiter.sv
// Scoreboard bench for frame_update_arbiter: directed frames,
// expected grants queued by stimulus, checked by a monitor.
module tb_frame_update_arbiter;

  localparam int N  = 4;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   vc;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_x;
  logic [N*CW-1:0] req_y;
  logic [N-1:0]    gnt;
  logic [N*CW-1:0] obj_x;
  logic [N*CW-1:0] obj_y;
  logic            upd_win;
  logic            frame_tick;
  logic [7:0]      frame_cnt;

  frame_update_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .vc         (vc),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .gnt        (gnt),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .upd_win    (upd_win),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int x;
    int y;
    int off;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   ticks = 0;
  int   mdl_x[N];
  int   mdl_y[N];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setreq(int i, int x, int y);
    req_x[i*CW +: CW] = CW'(x);
    req_y[i*CW +: CW] = CW'(y);
    req[i] = 1'b1;
  endtask

  task automatic push(int i, int x, int y, int off);
    exp_t e;
    e.idx = i;
    e.x   = x;
    e.y   = y;
    e.off = off;
    sbq.push_back(e);
  endtask

  task automatic check_objs(string nm);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", nm, i), int'(obj_x[i*CW +: CW]), mdl_x[i]);
      chk($sformatf("%s_y%0d", nm, i), int'(obj_y[i*CW +: CW]), mdl_y[i]);
    end
  endtask

  task automatic clr_mdl();
    for (int i = 0; i < N; i++) begin
      mdl_x[i] = 0;
      mdl_y[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tk(2);
    rst = 1'b0;
    clr_mdl();
  endtask

  task automatic frame(int w, int v);
    vc = 10'd511;
    tk(w);
    vc = 10'd200;
    tk(v);
  endtask

  // requester model: drops its req right after the grant edge
  always @(negedge clk) begin
    logic [N-1:0] d;
    if (|gnt) begin
      d = gnt;
      @(posedge clk);
      #1;
      req = req & ~d;
    end
  end

  // monitor: tick tracking and grant scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst || frame_tick) cyc = 0;
    else cyc++;
    if (frame_tick) ticks++;
    if (|gnt) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_gnt: got %b want 0", gnt);
      end else begin
        e = sbq.pop_front();
        chk("gnt_vec", int'(gnt), 1 << e.idx);
        chk("gnt_off", cyc, e.off);
        @(posedge clk);
        #1;
        mdl_x[e.idx] = e.x;
        mdl_y[e.idx] = e.y;
        chk("wr_x", int'(obj_x[e.idx*CW +: CW]), e.x);
        chk("wr_y", int'(obj_y[e.idx*CW +: CW]), e.y);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    clr_mdl();
    rst   = 1'b1;
    vc    = 10'd100;
    req   = '0;
    req_x = '0;
    req_y = '0;
    tk(3);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_win", int'(upd_win), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_cnt", int'(frame_cnt), 0);
    check_objs("rst_obj");
    rst = 1'b0;
    tk(4);
    chk("vis_win", int'(upd_win), 0);
    repeat (3) frame(10, 10);
    chk("t1_cnt", int'(frame_cnt), 3);

    // single request waits for blanking
    vc = 10'd200;
    setreq(0, 320, 400);
    push(0, 320, 400, 1);
    tk(8);
    vc = 10'd511;
    tk(1);
    chk("t2_win", int'(upd_win), 1);
    chk("t2_tick", int'(frame_tick), 1);
    tk(11);
    vc = 10'd200;
    tk(4);
    check_objs("t2_obj");
    chk("t2_req", int'(req), 0);

    // all four at once, pointer at 0
    do_reset();
    for (int i = 0; i < N; i++) begin
      setreq(i, 100 + i, 200 + i);
      push(i, 100 + i, 200 + i, 1 + 2 * i);
    end
    frame(16, 4);
    check_objs("t3_obj");
    chk("t3_q", sbq.size(), 0);

    // window closes after one grant; slot 1 carries over
    setreq(0, 50, 60);
    setreq(1, 70, 80);
    push(0, 50, 60, 1);
    push(1, 70, 80, 1);
    vc = 10'd520;
    tk(3);
    vc = 10'd31;
    tk(3);
    vc = 10'd200;
    tk(4);
    chk("t4_held_x1", int'(obj_x[1*CW +: CW]), 101);
    chk("t4_carry", int'(req), 2);
    check_objs("t4a_obj");
    frame(8, 4);
    check_objs("t4b_obj");
    chk("t4_q", sbq.size(), 0);

    // reset right after a grant mid-window
    setreq(2, 33, 44);
    push(2, 33, 44, 1);
    vc = 10'd511;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (gnt[2]) seen = 1'b1;
    end
    chk("t5_seen", int'(seen), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tk(1);
    rst = 1'b0;
    clr_mdl();
    chk("t5_cnt0", int'(frame_cnt), 0);
    chk("t5_gnt0", int'(gnt), 0);
    check_objs("t5a_obj");
    setreq(3, 77, 88);
    push(3, 77, 88, 1);
    tk(6);
    vc = 10'd200;
    tk(4);
    check_objs("t5b_obj");
    chk("t5_cnt1", int'(frame_cnt), 1);

    // frame counter wrap
    do_reset();
    ticks = 0;
    for (int f = 0; f < 256; f++) begin
      frame(2, 2);
      if (f == 254) chk("t6_cnt255", int'(frame_cnt), 255);
    end
    chk("t6_wrap", int'(frame_cnt), 0);
    chk("t6_ticks", ticks, 256);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
